simple_circuit_unit: RTL and testbench
======================================

// Module: simple_circuit_unit
// PURPOSE
//   Registered implementation of the 3-input gate network y = (a & b) | ~c.
//   Accepts one input vector {a,b,c} per cycle under in_valid, delivers y after a
//   fixed pipeline latency with out_valid, and keeps sticky coverage of all eight
//   input combinations seen. Small leaf block for the logic test harness.
// PARAMETERS
//   PIPE_STAGES  1  output latency in clk cycles; legal range 1..4 (others: elaboration error)
// PORTS
//   clk        in   1  rising-edge clock, sole clock domain
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  a/b/c sampled on this clk edge when high
//   a          in   1  input A
//   b          in   1  input B
//   c          in   1  input C
//   y          out  1  registered result (a & b) | ~c
//   out_valid  out  1  y holds a new result this cycle
//   y_comb     out  1  unregistered (a & b) | ~c of the current inputs, ignores in_valid
//   seen       out  8  sticky coverage; bit {a,b,c} set once that vector is accepted
//   all_seen   out  1  high when seen == 8'hFF
// BEHAVIOUR
//   - Reset: rst_n low asserts immediately regardless of clk; y=0, out_valid=0,
//     seen=8'h00, all_seen=0, all pipeline stages cleared (valid and data 0).
//     Removal is synchronised internally: first accept on 2nd clk edge after release.
//   - Function: f = (a & b) | ~c; truth table abc 000..111 -> 1,0,1,0,1,0,1,1.
//   - Pipeline: a vector accepted at edge N appears on y with out_valid=1 after
//     edge N+PIPE_STAGES-1 (PIPE_STAGES=1: valid the cycle after the accept edge).
//     One result per accepted vector; back-to-back in_valid gives back-to-back
//     out_valid; no backpressure, no drop, order preserved.
//   - When out_valid=0, y holds its last valid value (not forced to 0).
//   - in_valid=0: stage valid bit clears; data registers hold.
//   - seen: on each accepted vector, seen[{a,b,c}] <= 1 at the accept edge;
//     bits never clear except by reset. all_seen is registered from seen and
//     asserts the cycle after the final missing bit sets.
//   - Repeated vectors are legal; they re-set an already-set bit (no effect).
//   - Reset mid-operation: in-flight results discarded, out_valid never asserts
//     for vectors accepted before reset.
//   - y_comb purely combinational from a/b/c, live during reset.
//   - X on a/b/c while in_valid=0 must not propagate to y or seen.
// TESTING
//   - Reset: drive rst_n=0 mid-cycle -> y=0, out_valid=0, seen=00, all_seen=0 without clk edge.
//   - Sweep abc 000..111, one per 20 time units, in_valid=1 -> y seq 1,0,1,0,1,0,1,1,
//     each PIPE_STAGES cycles after accept; y_comb matches same values immediately.
//   - After sweep -> seen=8'hFF, all_seen=1 next cycle; apply 7 vectors only -> all_seen=0.
//   - Gaps: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed; y held during gap.
//   - PIPE_STAGES=3 with back-to-back 110,001 -> y 1 then 0 on consecutive valid cycles.
//   - Assert rst_n=0 with 2 vectors in flight (PIPE_STAGES=3) -> no out_valid after release.

Source files
------------

// File: rtl/simple_circuit_unit.sv
// Registered (a & b) | ~c gate network with a configurable output pipeline
// and sticky coverage of every input combination accepted.
module simple_circuit_unit #(
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       y,
    output logic       out_valid,
    output logic       y_comb,
    output logic [7:0] seen,
    output logic       all_seen
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("simple_circuit_unit: PIPE_STAGES must be 1..4");
    end

    logic                   rdy;
    logic                   accept;
    logic                   f_in;
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] dat;

    assign f_in   = (a & b) | ~c;
    assign y_comb = f_in;
    assign accept = in_valid & rdy;

    // Reset release is taken one edge late so the first accept is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= accept;
            if (accept) begin
                dat[0] <= f_in;
            end
            // Bubbles clear valid but leave data in place, so y holds.
            for (int k = 1; k < PIPE_STAGES; k++) begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    dat[k] <= dat[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen     <= 8'h00;
            all_seen <= 1'b0;
        end else begin
            if (accept) begin
                seen[{a, b, c}] <= 1'b1;
            end
            all_seen <= &seen;
        end
    end

    assign y         = dat[PIPE_STAGES-1];
    assign out_valid = vld[PIPE_STAGES-1];

endmodule

// File: tb/tb_simple_circuit_unit.sv
// Directed-vector bench for simple_circuit_unit at PIPE_STAGES 1 and 3.
module tb_simple_circuit_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       a;
    logic       b;
    logic       c;

    logic       y1, ov1, yc1, all1;
    logic [7:0] seen1;
    logic       y3, ov3, yc3, all3;
    logic [7:0] seen3;

    int n_vec;
    int n_err;

    logic [7:0] tt;

    simple_circuit_unit #(.PIPE_STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c),
        .y(y1), .out_valid(ov1), .y_comb(yc1),
        .seen(seen1), .all_seen(all1)
    );

    simple_circuit_unit #(.PIPE_STAGES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c),
        .y(y3), .out_valid(ov3), .y_comb(yc3),
        .seen(seen3), .all_seen(all3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] abc);
        in_valid = v;
        {a, b, c} = abc;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        // truth table abc 000..111 -> 1,0,1,0,1,0,1,1
        tt = 8'hD5;
        rst_n = 1'b1;
        drive(1'b0, 3'b000);

        // Asynchronous reset, no clock edge yet
        #3 rst_n = 1'b0;
        #1;
        check("rst_y", y1, 0);
        check("rst_ov", ov1, 0);
        check("rst_seen", seen1, 8'h00);
        check("rst_all", all1, 0);
        check("rst_ov3", ov3, 0);

        @(negedge clk);
        @(negedge clk);
        // Release with a vector already offered: first edge must not accept it
        rst_n = 1'b1;
        drive(1'b1, 3'b111);
        @(negedge clk);
        check("sync_ov", ov1, 0);
        check("sync_seen", seen1, 8'h00);

        // Sweep all eight vectors back to back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i));
            #1;
            check($sformatf("ycomb_%0d", i), yc1, tt[i]);
            @(negedge clk);
            check($sformatf("sw_y_%0d", i), y1, tt[i]);
            check($sformatf("sw_ov_%0d", i), ov1, 1);
            if (i >= 2) begin
                check($sformatf("sw3_y_%0d", i - 2), y3, tt[i-2]);
                check($sformatf("sw3_ov_%0d", i - 2), ov3, 1);
            end
        end
        drive(1'b0, 3'b000);
        check("sweep_seen", seen1, 8'hFF);
        check("sweep_all_early", all1, 0);
        @(negedge clk);
        check("sweep_all", all1, 1);
        check("sweep_all3", all3, 1);
        check("drain1_ov", ov1, 0);
        check("drain1_y", y1, 1);
        check("sw3_y_6", y3, tt[6]);
        check("sw3_ov_6", ov3, 1);
        @(negedge clk);
        check("sw3_y_7", y3, tt[7]);
        check("sw3_ov_7", ov3, 1);
        @(negedge clk);
        check("drain3_ov", ov3, 0);

        // Gap pattern 1,0,1 with X on the inputs during the bubble
        drive(1'b1, 3'b011);
        @(negedge clk);
        check("gap_ov_a", ov1, 1);
        check("gap_y_a", y1, 0);
        in_valid = 1'b0;
        a = 1'bx;
        b = 1'bx;
        c = 1'bx;
        @(negedge clk);
        check("gap_ov_b", ov1, 0);
        check("gap_y_hold", y1, 0);
        check("gap_seen_x", seen1, 8'hFF);
        drive(1'b1, 3'b110);
        @(negedge clk);
        check("gap_ov_c", ov1, 1);
        check("gap_y_c", y1, 1);
        check("gap3_ov_a", ov3, 1);
        check("gap3_y_a", y3, 0);
        // Back-to-back 110, 001 into the 3-stage pipe
        drive(1'b1, 3'b001);
        @(negedge clk);
        check("gap3_ov_b", ov3, 0);
        check("gap3_y_hold", y3, 0);
        drive(1'b0, 3'b000);
        @(negedge clk);
        check("b2b_ov_a", ov3, 1);
        check("b2b_y_a", y3, 1);
        @(negedge clk);
        check("b2b_ov_b", ov3, 1);
        check("b2b_y_b", y3, 0);
        @(negedge clk);
        check("b2b_ov_end", ov3, 0);

        // Reset with two vectors in flight in the 3-stage pipe
        drive(1'b1, 3'b110);
        @(negedge clk);
        drive(1'b1, 3'b111);
        @(negedge clk);
        drive(1'b0, 3'b000);
        #5 rst_n = 1'b0;
        #1;
        check("mid_rst_ov3", ov3, 0);
        check("mid_rst_y3", y3, 0);
        check("mid_rst_seen", seen3, 8'h00);
        check("mid_rst_all", all3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("flush_ov3_%0d", i), ov3, 0);
        end

        // Seven of eight vectors must leave all_seen low
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3'(i));
            @(negedge clk);
        end
        drive(1'b0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check("seven_seen", seen1, 8'h7F);
        check("seven_all", all1, 0);
        check("seven_all3", all3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
